fpu_wb_collector: RTL and testbench

Consumer end of the FPU result interface: collects (tdata, rt, rt_flag) results from all u/l-lane FPU units (fadd, fsub, fmul, fdiv, fsqrt, ftoi, itof), which have differing latencies.
Buffers each source in a small per-source FIFO.
Drains at most two results per cycle to the register-file write ports using round-robin arbitration.
Raises stall toward the issue logic before any FIFO can overflow. Sits between the FPU output interfaces and writeback.

---
 rtl/fpu_wb_collector.sv | 159 +++++++++++++++
 tb/tb_fpu_wb_collector.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_wb_collector.sv
// FPU result collector: buffers each unit's result stream in its own small FIFO and
// drains up to two results per cycle to the register-file write ports, round-robin.
module fpu_wb_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 37
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    i_push,
  input  logic                    i_pop,
  input  logic [W-1:0]            i_data,
  output logic [W-1:0]            o_head,
  output logic                    o_empty,
  output logic [$clog2(DEPTH):0]  o_cnt_nxt,
  output logic                    o_drop
);
  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0]   r_cnt;
  logic          w_full, w_acc;

  // a pop frees a slot at the same edge, so a full FIFO still accepts a push then
  assign w_full    = (r_cnt == (AW+1)'(DEPTH));
  assign w_acc     = i_push && (!w_full || i_pop);
  assign o_drop    = i_push && w_full && !i_pop;
  assign o_empty   = (r_cnt == '0);
  assign o_head    = r_mem[r_rp];
  assign o_cnt_nxt = r_cnt + (AW+1)'(w_acc) - (AW+1)'(i_pop);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_acc) r_wp <= r_wp + AW'(1);
      if (i_pop) r_rp <= r_rp + AW'(1);
      r_cnt <= o_cnt_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && w_acc) r_mem[r_wp] <= i_data;
  end
endmodule

module fpu_wb_collector #(
  parameter int N_SRC = 14,
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [N_SRC-1:0]      src_valid,
  input  logic [5*N_SRC-1:0]    src_rt,
  input  logic [32*N_SRC-1:0]   src_tdata,
  output logic                  wr0_en,
  output logic [4:0]            wr0_rt,
  output logic [31:0]           wr0_data,
  output logic                  wr1_en,
  output logic [4:0]            wr1_rt,
  output logic [31:0]           wr1_data,
  output logic                  stall,
  output logic                  pending,
  output logic                  overflow
);
  localparam int IW = (N_SRC > 1) ? $clog2(N_SRC) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  logic [N_SRC-1:0][36:0]   w_head;
  logic [N_SRC-1:0][CW-1:0] w_cnt_nxt;
  logic [N_SRC-1:0]         w_empty, w_drop, w_pop;
  logic [IW-1:0]            r_rr, w_g0_idx, w_g1_idx, w_last, w_rr_nxt;
  logic                     w_g0_vld, w_g1_vld, w_stall_nxt, w_pend_nxt;

  for (genvar g = 0; g < N_SRC; g++) begin : g_src
    fpu_wb_fifo #(.DEPTH(DEPTH), .W(37)) u_fifo (
      .clk       (clk),
      .rstn      (rstn),
      .i_push    (src_valid[g]),
      .i_pop     (w_pop[g]),
      .i_data    ({src_rt[5*g +: 5], src_tdata[32*g +: 32]}),
      .o_head    (w_head[g]),
      .o_empty   (w_empty[g]),
      .o_cnt_nxt (w_cnt_nxt[g]),
      .o_drop    (w_drop[g])
    );
  end

  // Scan from r_rr; port 1 skips heads aiming at port 0's register so both
  // ports never write the same rt and same-rt results stay in order.
  always_comb begin
    int idx;
    idx      = 0;
    w_g0_vld = 1'b0;
    w_g1_vld = 1'b0;
    w_g0_idx = '0;
    w_g1_idx = '0;
    w_pop    = '0;
    for (int k = 0; k < N_SRC; k++) begin
      idx = int'(r_rr) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (!w_empty[idx]) begin
        if (!w_g0_vld) begin
          w_g0_vld = 1'b1;
          w_g0_idx = IW'(idx);
        end else if (!w_g1_vld && (w_head[idx][36:32] != w_head[w_g0_idx][36:32])) begin
          w_g1_vld = 1'b1;
          w_g1_idx = IW'(idx);
        end
      end
    end
    if (w_g0_vld) w_pop[w_g0_idx] = 1'b1;
    if (w_g1_vld) w_pop[w_g1_idx] = 1'b1;
  end

  assign w_last   = w_g1_vld ? w_g1_idx : w_g0_idx;
  assign w_rr_nxt = (w_last == IW'(N_SRC-1)) ? '0 : w_last + IW'(1);

  always_comb begin
    w_stall_nxt = 1'b0;
    w_pend_nxt  = 1'b0;
    for (int i = 0; i < N_SRC; i++) begin
      if (w_cnt_nxt[i] >= CW'(DEPTH-1)) w_stall_nxt = 1'b1;
      if (w_cnt_nxt[i] != '0)           w_pend_nxt  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      r_rr     <= '0;
      wr0_en   <= 1'b0;
      wr0_rt   <= '0;
      wr0_data <= '0;
      wr1_en   <= 1'b0;
      wr1_rt   <= '0;
      wr1_data <= '0;
      stall    <= 1'b0;
      pending  <= 1'b0;
      overflow <= 1'b0;
    end else begin
      wr0_en <= w_g0_vld;
      wr1_en <= w_g1_vld;
      if (w_g0_vld) begin
        wr0_rt   <= w_head[w_g0_idx][36:32];
        wr0_data <= w_head[w_g0_idx][31:0];
        r_rr     <= w_rr_nxt;
      end
      if (w_g1_vld) begin
        wr1_rt   <= w_head[w_g1_idx][36:32];
        wr1_data <= w_head[w_g1_idx][31:0];
      end
      stall   <= w_stall_nxt;
      pending <= w_pend_nxt;
      if (|w_drop) overflow <= 1'b1;
    end
  end
endmodule

// File: tb/tb_fpu_wb_collector.sv
// Scoreboard bench for fpu_wb_collector: directed pushes queue the expected writes,
// a negedge monitor pops and compares every write-port transaction.
module tb_fpu_wb_collector;
  localparam int N_SRC = 14;
  localparam int DEPTH = 4;

  typedef struct packed {
    logic        port;
    logic [4:0]  rt;
    logic [31:0] data;
  } exp_t;

  logic                  clk = 1'b0;
  logic                  rstn;
  logic [N_SRC-1:0]      src_valid;
  logic [5*N_SRC-1:0]    src_rt;
  logic [32*N_SRC-1:0]   src_tdata;
  logic                  wr0_en, wr1_en, stall, pending, overflow;
  logic [4:0]            wr0_rt, wr1_rt;
  logic [31:0]           wr0_data, wr1_data;

  exp_t exp_q [$];
  int   n_cmp = 0;
  int   n_err = 0;

  fpu_wb_collector #(.N_SRC(N_SRC), .DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .src_valid(src_valid), .src_rt(src_rt), .src_tdata(src_tdata),
    .wr0_en(wr0_en), .wr0_rt(wr0_rt), .wr0_data(wr0_data),
    .wr1_en(wr1_en), .wr1_rt(wr1_rt), .wr1_data(wr1_data),
    .stall(stall), .pending(pending), .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic mon_write(input logic port, input logic [4:0] rt, input logic [31:0] data);
    exp_t e;
    n_cmp++;
    if (exp_q.size() == 0) begin
      n_err++;
      $display("FAIL unexpected_write: port %0d rt %0d data %h, nothing expected (t=%0t)",
               port, rt, data, $time);
    end else begin
      e = exp_q.pop_front();
      if (e !== {port, rt, data}) begin
        n_err++;
        $display("FAIL write: got port %0d rt %0d data %h expected port %0d rt %0d data %h (t=%0t)",
                 port, rt, data, e.port, e.rt, e.data, $time);
      end
    end
  endtask

  always @(negedge clk) begin
    if (wr0_en === 1'b1) mon_write(1'b0, wr0_rt, wr0_data);
    if (wr1_en === 1'b1) mon_write(1'b1, wr1_rt, wr1_data);
    if (wr0_en === 1'b1 && wr1_en === 1'b1) begin
      n_cmp++;
      if (wr0_rt == wr1_rt) begin
        n_err++;
        $display("FAIL same_rt_both_ports: wr0_rt %0d wr1_rt %0d, required distinct", wr0_rt, wr1_rt);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_src(input int i, input logic [4:0] rt, input logic [31:0] d);
    src_valid[i]        = 1'b1;
    src_rt[5*i +: 5]    = rt;
    src_tdata[32*i +: 32] = d;
  endtask

  task automatic expect_wr(input logic port, input logic [4:0] rt, input logic [31:0] d);
    exp_t e;
    e.port = port;
    e.rt   = rt;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    rstn      = 1'b0;
    src_valid = '0;
    repeat (2) tick();
    rstn = 1'b1;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      tick();
      n++;
    end
    tick();
    chk(name, exp_q.size(), 0);
  endtask

  initial begin
    // reset held with every source valid: nothing may be captured
    rstn      = 1'b0;
    src_valid = '1;
    src_rt    = '1;
    src_tdata = '1;
    repeat (2) tick();
    rstn      = 1'b1;
    src_valid = '0;
    tick();
    chk("rst_wr0_en", wr0_en, 0);
    chk("rst_wr1_en", wr1_en, 0);
    chk("rst_wr0_rt", wr0_rt, 0);
    chk("rst_wr0_data", wr0_data, 0);
    chk("rst_wr1_rt", wr1_rt, 0);
    chk("rst_wr1_data", wr1_data, 0);
    chk("rst_stall", stall, 0);
    chk("rst_pending", pending, 0);
    chk("rst_overflow", overflow, 0);
    repeat (3) tick();
    chk("rst_pending_later", pending, 0);

    // single result, two-cycle latency
    push_src(3, 5'd5, 32'h3F80_0000);
    expect_wr(1'b0, 5'd5, 32'h3F80_0000);
    tick();
    chk("single_pending_t1", pending, 1);
    chk("single_wr0_en_t1", wr0_en, 0);
    src_valid = '0;
    tick();
    chk("single_wr0_en_t2", wr0_en, 1);
    chk("single_wr0_rt", wr0_rt, 5);
    chk("single_wr0_data", wr0_data, 32'h3F80_0000);
    chk("single_wr1_en", wr1_en, 0);
    chk("single_pending_t2", pending, 0);
    tick();

    // a buffered result is discarded by reset
    push_src(8, 5'd30, 32'hDEAD_BEEF);
    tick();
    do_reset();
    tick();
    chk("midrst_pending", pending, 0);

    // dual drain from rr_ptr=0
    push_src(0, 5'd1, 32'hA0);
    push_src(1, 5'd2, 32'hA1);
    push_src(2, 5'd3, 32'hA2);
    expect_wr(1'b0, 5'd1, 32'hA0);
    expect_wr(1'b1, 5'd2, 32'hA1);
    expect_wr(1'b0, 5'd3, 32'hA2);
    tick();
    src_valid = '0;
    tick();
    chk("dual_both_en", {wr0_en, wr1_en}, 2'b11);
    tick();
    chk("dual_second_en", {wr0_en, wr1_en}, 2'b10);
    tick();

    // same rt from sources 4,5 with rr_ptr=3; port 1 goes to src 2 after wrap
    push_src(4, 5'd7, 32'hB4);
    push_src(5, 5'd7, 32'hB5);
    push_src(2, 5'd9, 32'hC2);
    expect_wr(1'b0, 5'd7, 32'hB4);
    expect_wr(1'b1, 5'd9, 32'hC2);
    expect_wr(1'b0, 5'd7, 32'hB5);
    tick();
    src_valid = '0;
    drain("conflict_drain");

    // stall/overflow: all heads share rt 3, so one grant per cycle
    do_reset();
    for (int i = 1; i < N_SRC; i++) begin
      push_src(i, 5'd3, 32'h5000_0000 + i);
      expect_wr(1'b0, 5'd3, 32'h5000_0000 + i);
    end
    tick();
    for (int k = 0; k < 5; k++) begin
      src_valid = '0;
      push_src(0, 5'd3, 32'h0A0 + k);
      if (k < 4) expect_wr(1'b0, 5'd3, 32'h0A0 + k);
      tick();
      if (k < 2)  chk("fill_stall_low", stall, 0);
      if (k >= 2) chk("fill_stall_high", stall, 1);
      if (k < 4)  chk("fill_no_overflow", overflow, 0);
    end
    chk("overflow_set", overflow, 1);
    src_valid = '0;
    repeat (8) tick();
    // push on the edge that pops a full FIFO is accepted
    push_src(0, 5'd3, 32'h0AF);
    expect_wr(1'b0, 5'd3, 32'h0AF);
    tick();
    src_valid = '0;
    chk("full_pushpop_stall", stall, 1);
    tick();
    chk("drain_stall_cnt3", stall, 1);
    tick();
    chk("drain_stall_cnt2", stall, 0);
    drain("overflow_drain");
    chk("overflow_sticky", overflow, 1);
    chk("overflow_pending", pending, 0);
    do_reset();
    tick();
    chk("overflow_cleared", overflow, 0);

    // pointer wrap: ten in-order results through one source
    for (int k = 0; k < 10; k++) begin
      push_src(6, 5'(k), 32'h6000_0000 + k);
      expect_wr(1'b0, 5'(k), 32'h6000_0000 + k);
      tick();
      chk("wrap_no_stall", stall, 0);
    end
    src_valid = '0;
    drain("wrap_drain");
    chk("wrap_no_overflow", overflow, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
